// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming code geometry helpers shared by the SEC-DED encoder and decoder
package hamming_pkg;

   function automatic int calc_p(input int data_w);
      int p;
      p = 1;
      while ((1 << p) < data_w + p + 1) p++;
      return p;
   endfunction

   function automatic bit is_pow2(input int x);
      return (x > 0) && ((x & (x - 1)) == 0);
   endfunction

   // data bits occupy the non-power-of-two positions, data[0] at position 3
   function automatic int data_pos(input int idx);
      int pos;
      int cnt;
      pos = 2;
      cnt = -1;
      while (cnt < idx) begin
         pos++;
         if (!is_pow2(pos)) cnt++;
      end
      return pos;
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational syndrome and overall parity of an extended Hamming codeword
module hamming_syndrome
   import hamming_pkg::*;
#(
   parameter int DATA_W = 4,
   localparam int P = calc_p(DATA_W),
   localparam int CODE_W = DATA_W + P + 1
) (
   input  logic [CODE_W-1:0] code,
   output logic [P-1:0]      syndrome,
   output logic              parity
);

   always_comb begin
      syndrome = '0;
      for (int i = 1; i < CODE_W; i++) begin
         if (code[i]) syndrome = syndrome ^ P'(i);
      end
   end

   assign parity = ^code;

endmodule

// File: rtl/hamming_secded_decoder.sv
// rtl/hamming_secded_decoder.sv - two-stage pipelined SEC-DED decoder with saturating error counters
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int CNT_W = 16,
   localparam int P = calc_p(DATA_W),
   localparam int CODE_W = DATA_W + P + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_corrected,
   output logic              out_uncorrectable,
   output logic [P-1:0]      out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [P-1:0]      s1_syn;
   logic              s1_par;
   logic              s2_valid;
   logic [P-1:0]      syn;
   logic              par;
   logic              s1_load;
   logic              s2_load;
   logic              corr;
   logic              uncorr;
   logic [DATA_W-1:0] raw_data;
   logic [DATA_W-1:0] ext_data;
   logic              out_fire;

   hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
      .code     (in_code),
      .syndrome (syn),
      .parity   (par)
   );

   assign s2_load   = !s2_valid || out_ready;
   assign s1_load   = !s1_valid || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid;
   assign out_fire  = s2_valid && out_ready;

   // Only the data positions of the codeword are needed after the syndrome is known.
   for (genvar d = 0; d < DATA_W; d++) begin : g_data
      assign raw_data[d] = in_code[data_pos(d)];
      assign ext_data[d] = s1_data[d] ^ (corr && (int'(s1_syn) == data_pos(d)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= raw_data;
            s1_syn  <= syn;
            s1_par  <= par;
         end
      end
   end

   // odd parity with a syndrome beyond the last position only happens in shortened codes
   always_comb begin
      corr   = 1'b0;
      uncorr = 1'b0;
      if (s1_par) begin
         if (int'(s1_syn) < CODE_W) corr = 1'b1;
         else                       uncorr = 1'b1;
      end else if (s1_syn != '0) begin
         uncorr = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid          <= 1'b0;
         out_data          <= '0;
         out_corrected     <= 1'b0;
         out_uncorrectable <= 1'b0;
         out_syndrome      <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data          <= ext_data;
            out_corrected     <= corr;
            out_uncorrectable <= uncorr;
            out_syndrome      <= s1_syn;
         end
      end
   end

   // a clear in the same cycle as a counted handshake drops that event
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (out_fire) begin
         if (out_corrected && (corr_cnt != '1))
            corr_cnt <= corr_cnt + CNT_W'(1);
         if (out_uncorrectable && (uncorr_cnt != '1))
            uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb/tb_hamming_secded_decoder.sv - self-checking bench for hamming_secded_decoder
module tb_hamming_secded_decoder;

   typedef struct packed {
      logic [3:0] data;
      logic       corr;
      logic       unc;
      logic [2:0] syn;
   } exp_t;

   typedef struct {
      logic [7:0] code;
      exp_t       exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic        out_corrected, out_uncorrectable, cnt_clr;
   logic [7:0]  in_code;
   logic [3:0]  out_data;
   logic [2:0]  out_syndrome;
   logic [15:0] corr_cnt, uncorr_cnt;

   logic        sat_in_ready, sat_out_valid, sat_corr, sat_unc;
   logic [3:0]  sat_data;
   logic [2:0]  sat_syn;
   logic [1:0]  sat_corr_cnt, sat_uncorr_cnt;

   logic        in5_valid, in5_ready, out5_valid, out5_ready, out5_corr, out5_unc, clr5;
   logic [9:0]  in5_code;
   logic [4:0]  out5_data;
   logic [3:0]  out5_syn;
   logic [15:0] c5_corr, c5_unc;

   hamming_secded_decoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
      .out_syndrome(out_syndrome), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   hamming_secded_decoder #(.DATA_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .in_code(in_code),
      .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_data),
      .out_corrected(sat_corr), .out_uncorrectable(sat_unc),
      .out_syndrome(sat_syn), .cnt_clr(cnt_clr), .corr_cnt(sat_corr_cnt), .uncorr_cnt(sat_uncorr_cnt)
   );

   hamming_secded_decoder #(.DATA_W(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in5_valid), .in_ready(in5_ready), .in_code(in5_code),
      .out_valid(out5_valid), .out_ready(out5_ready), .out_data(out5_data),
      .out_corrected(out5_corr), .out_uncorrectable(out5_unc),
      .out_syndrome(out5_syn), .cnt_clr(clr5), .corr_cnt(c5_corr), .uncorr_cnt(c5_unc)
   );

   int n_tests = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // reference encoder straight from the code definition
   function automatic logic [7:0] encode(input logic [3:0] d);
      logic [7:0] c;
      logic       b;
      int         j;
      c = '0;
      j = 0;
      for (int pos = 1; pos < 8; pos++) begin
         if (pos != 1 && pos != 2 && pos != 4) begin
            c[pos] = d[j];
            j++;
         end
      end
      for (int k = 0; k < 3; k++) begin
         b = 1'b0;
         for (int pos = 1; pos < 8; pos++)
            if (pos[k]) b = b ^ c[pos];
         c[1 << k] = b;
      end
      c[0] = ^c[7:1];
      return c;
   endfunction

   function automatic logic [3:0] extract(input logic [7:0] c);
      return {c[7], c[6], c[5], c[3]};
   endfunction

   function automatic vec_t mk(input logic [7:0] c, input logic [3:0] d, input logic cr,
                               input logic un, input logic [2:0] s);
      vec_t v;
      v.code     = c;
      v.exp.data = d;
      v.exp.corr = cr;
      v.exp.unc  = un;
      v.exp.syn  = s;
      return v;
   endfunction

   // expectation follows from which positions were flipped, not from a syndrome calculation
   task automatic gen(output logic [7:0] code, output exp_t e);
      logic [3:0] d;
      int nf, a, b;
      d    = 4'($urandom_range(0, 15));
      nf   = int'($urandom_range(0, 2));
      a    = int'($urandom_range(0, 7));
      b    = (a + int'($urandom_range(1, 7))) % 8;
      code = encode(d);
      e    = '{data: d, corr: 1'b0, unc: 1'b0, syn: 3'd0};
      if (nf >= 1) code[a] = ~code[a];
      if (nf == 1) begin
         e.corr = 1'b1;
         e.syn  = 3'(a);
      end
      if (nf == 2) begin
         code[b] = ~code[b];
         e.unc   = 1'b1;
         e.syn   = 3'(a ^ b);
         e.data  = extract(code);
      end
   endtask

   exp_t        exp_q[$];
   exp_t        cur_exp;
   exp_t        m_e;
   bit          mon_en = 1'b0;
   bit          hold_pend = 1'b0;
   logic [8:0]  held;
   logic [1:0]  m_bump;
   int          m_corr = 0, m_unc = 0, m_scorr = 0, m_sunc = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("corr_cnt", 32'(corr_cnt), m_corr);
         chk("uncorr_cnt", 32'(uncorr_cnt), m_unc);
         chk("sat_corr_cnt", 32'(sat_corr_cnt), m_scorr);
         chk("sat_uncorr_cnt", 32'(sat_uncorr_cnt), m_sunc);
         chk("flag_excl", 32'(out_corrected & out_uncorrectable), 0);
         if (hold_pend) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_hold", 32'({out_data, out_corrected, out_uncorrectable, out_syndrome}), 32'(held));
         end
         if (rst) begin
            exp_q.delete();
            m_corr = 0; m_unc = 0; m_scorr = 0; m_sunc = 0;
            hold_pend = 1'b0;
         end else begin
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            m_bump = 2'b00;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  m_e = exp_q.pop_front();
                  chk("sb_data", 32'(out_data), 32'(m_e.data));
                  chk("sb_corr", 32'(out_corrected), 32'(m_e.corr));
                  chk("sb_unc", 32'(out_uncorrectable), 32'(m_e.unc));
                  chk("sb_syn", 32'(out_syndrome), 32'(m_e.syn));
                  chk("sat_valid", 32'(sat_out_valid), 1);
                  chk("sat_word", 32'({sat_data, sat_corr, sat_unc, sat_syn}), 32'(m_e));
                  m_bump = {m_e.unc, m_e.corr};
               end
            end
            if (cnt_clr) begin
               m_corr = 0; m_unc = 0; m_scorr = 0; m_sunc = 0;
            end else begin
               if (m_bump[0]) begin
                  if (m_corr < 65535) m_corr++;
                  if (m_scorr < 3) m_scorr++;
               end
               if (m_bump[1]) begin
                  if (m_unc < 65535) m_unc++;
                  if (m_sunc < 3) m_sunc++;
               end
            end
            hold_pend = out_valid && !out_ready;
            held = {out_data, out_corrected, out_uncorrectable, out_syndrome};
         end
      end
   end

   // called just after a rising edge; returns just after the edge that took the word
   task automatic send(input logic [7:0] code, input exp_t e, input bit rnd, output int cycles);
      bit done;
      done   = 1'b0;
      cycles = 0;
      in_valid = 1'b1;
      in_code  = code;
      cur_exp  = e;
      while (!done && cycles < 64) begin
         if (rnd) begin
            out_ready = 1'($urandom_range(0, 1));
            cnt_clr   = ($urandom_range(0, 31) == 0);
         end
         @(negedge clk);
         done = in_ready;
         cycles++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) chk("in_ready_timeout", 0, 1);
   endtask

   task automatic send5(input logic [9:0] code, input logic [4:0] d, input logic c,
                        input logic u, input logic [3:0] s);
      in5_valid = 1'b1;
      in5_code  = code;
      @(negedge clk);
      chk("d5_in_ready", 32'(in5_ready), 1);
      @(posedge clk);
      #1;
      in5_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("d5_valid", 32'(out5_valid), 1);
      chk("d5_data", 32'(out5_data), 32'(d));
      chk("d5_corr", 32'(out5_corr), 32'(c));
      chk("d5_unc", 32'(out5_unc), 32'(u));
      chk("d5_syn", 32'(out5_syn), 32'(s));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   vec_t       tbl[9];
   int         cyc, tot;
   logic [7:0] rcode;
   exp_t       rexp;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
      cur_exp = '0; in5_valid = 1'b0; in5_code = '0; out5_ready = 1'b1; clr5 = 1'b0;

      tbl[0] = mk(8'hAA, 4'hB, 1'b0, 1'b0, 3'd0);
      tbl[1] = mk(8'h8A, 4'hB, 1'b1, 1'b0, 3'd5);
      tbl[2] = mk(8'hAB, 4'hB, 1'b1, 1'b0, 3'd0);
      tbl[3] = mk(8'hCA, 4'hD, 1'b0, 1'b1, 3'd3);
      tbl[4] = mk(8'hFF, 4'hF, 1'b0, 1'b0, 3'd0);
      tbl[5] = mk(8'h7F, 4'hF, 1'b1, 1'b0, 3'd7);
      tbl[6] = mk(8'hF9, 4'hF, 1'b0, 1'b1, 3'd3);
      tbl[7] = mk(8'h08, 4'h0, 1'b1, 1'b0, 3'd3);
      tbl[8] = mk(8'h00, 4'h0, 1'b0, 1'b0, 3'd0);

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_word", 32'({out_data, out_corrected, out_uncorrectable, out_syndrome}), 0);
      chk("rst_counters", 32'({corr_cnt, uncorr_cnt}), 0);
      chk("rst_sat_counters", 32'({sat_corr_cnt, sat_uncorr_cnt}), 0);
      chk("rst_d5_counters", 32'({c5_corr, c5_unc}), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_sat_in_ready", 32'(sat_in_ready), 1);
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         send(tbl[i].code, tbl[i].exp, 1'b0, cyc);
         @(negedge clk);
         chk("tbl_latency", 32'(out_valid), 0);
         @(negedge clk);
         chk("tbl_valid", 32'(out_valid), 1);
         chk("tbl_data", 32'(out_data), 32'(tbl[i].exp.data));
         chk("tbl_corr", 32'(out_corrected), 32'(tbl[i].exp.corr));
         chk("tbl_unc", 32'(out_uncorrectable), 32'(tbl[i].exp.unc));
         chk("tbl_syn", 32'(out_syndrome), 32'(tbl[i].exp.syn));
         @(posedge clk);
         #1;
      end
      chk("tbl_corr_cnt", 32'(corr_cnt), 4);
      chk("tbl_uncorr_cnt", 32'(uncorr_cnt), 2);
      chk("tbl_sat_corr_cnt", 32'(sat_corr_cnt), 3);
      chk("tbl_sat_uncorr_cnt", 32'(sat_uncorr_cnt), 2);

      for (int w = 0; w < 300; w++) begin
         gen(rcode, rexp);
         if ($urandom_range(0, 7) == 0) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
         send(rcode, rexp, 1'b1, cyc);
      end
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_empty", 32'(exp_q.size()), 0);

      tot = 0;
      for (int w = 0; w < 8; w++) begin
         gen(rcode, rexp);
         send(rcode, rexp, 1'b0, cyc);
         tot += cyc;
      end
      chk("full_rate_cycles", tot, 8);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("full_rate_drain", 32'(exp_q.size()), 0);
      @(posedge clk);
      #1;

      out_ready = 1'b0;
      send(8'h8A, '{data: 4'hB, corr: 1'b1, unc: 1'b0, syn: 3'd5}, 1'b0, cyc);
      send(8'h8A, '{data: 4'hB, corr: 1'b1, unc: 1'b0, syn: 3'd5}, 1'b0, cyc);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_counters", 32'({corr_cnt, uncorr_cnt}), 0);
      chk("midrst_sat_counters", 32'({sat_corr_cnt, sat_uncorr_cnt}), 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_no_output", 32'(out_valid), 0);

      send(8'h8A, '{data: 4'hB, corr: 1'b1, unc: 1'b0, syn: 3'd5}, 1'b0, cyc);
      repeat (2) @(posedge clk);
      #1;
      chk("clr_pre_corr_cnt", 32'(corr_cnt), 1);
      send(8'h8A, '{data: 4'hB, corr: 1'b1, unc: 1'b0, syn: 3'd5}, 1'b0, cyc);
      @(posedge clk);
      #1;
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      chk("clr_wins_corr_cnt", 32'(corr_cnt), 0);
      chk("clr_wins_sat_corr_cnt", 32'(sat_corr_cnt), 0);
      @(posedge clk);
      #1;

      send5(10'h00F, 5'h01, 1'b0, 1'b0, 4'd0);
      send5(10'h20F, 5'h01, 1'b1, 1'b0, 4'd9);
      send5(10'h11E, 5'h01, 1'b0, 1'b1, 4'd12);
      send5(10'h18E, 5'h09, 1'b0, 1'b1, 4'd15);
      chk("d5_corr_cnt", 32'(c5_corr), 1);
      chk("d5_uncorr_cnt", 32'(c5_unc), 2);

      chk("final_queue_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hamming_secded_decoder.md
# hamming_secded_decoder

Parametrised, pipelined SEC-DED (extended Hamming) decoder. It is the receive-side successor to the team's 4-bit Hamming encoder, generalised to any data width. Each codeword is streamed in over a valid/ready handshake. The block corrects single-bit errors, flags double-bit errors, and keeps saturating error statistics. It sits between the storage or link read path and the consumer, at one word per cycle.

## Interface
- `DATA_W`, default 4: data bits per word; must be ≥ 1.
- `CNT_W`, default 16: width of each error counter.
- `P`, derived, not overridable: smallest integer with 2^P ≥ DATA_W+P+1.
- `CODE_W`, derived: DATA_W+P+1.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input codeword valid.
- `in_ready`  out  1  decoder can accept a codeword.
- `in_code`  in  CODE_W  received codeword.
- `out_valid`  out  1  decoded word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_W  corrected data, or raw data when uncorrectable.
- `out_corrected`  out  1  a single-bit error was corrected.
- `out_uncorrectable`  out  1  double or invalid error detected.
- `out_syndrome`  out  P  Hamming syndrome, for debug.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `corr_cnt`  out  CNT_W  count of corrected words, saturating.
- `uncorr_cnt`  out  CNT_W  count of uncorrectable words, saturating.

## Operation
- **Codeword layout.** Bit i is Hamming position i.
  - Position 0 is the overall parity bit.
  - Powers of two (1, 2, 4, …) are check bits.
  - Remaining positions hold data in ascending order, data[0] at position 3.
  - A valid codeword has even parity over all CODE_W bits.
  - Each check bit at position 2^k is the XOR of all positions 1..CODE_W-1 whose index has bit k set.
- **Stage 1.** Computes:
  - syndrome s: XOR of the indices of set bits in positions 1..CODE_W-1;
  - overall parity p: XOR of all CODE_W bits.
  - Registers s, p and in_code.
- **Stage 2.** Classifies and registers the result:
  - s=0, p=0: no error. Data is extracted unchanged; both flags are 0.
  - p=1, s<CODE_W: single error. Invert position s (s=0 means the parity bit itself), extract data, out_corrected=1.
  - p=0, s≠0: double error. Extract raw data, out_uncorrectable=1.
  - p=1, s≥CODE_W: invalid position, possible only when the code is shortened. Treat as uncorrectable; raw data.
  - out_syndrome=s in all cases.
- **Counters.**
  - Increment only on an output handshake (out_valid & out_ready) whose word carries the matching flag.
  - Saturate at 2^CNT_W-1.
  - When cnt_clr and an increment coincide, clear wins: the counter goes to 0 and that event is not counted.

## Timing
- **Reset.** All of the following are 0 one cycle after rst is sampled high: out_valid, both pipeline valids, out_data, out_corrected, out_uncorrectable, out_syndrome, corr_cnt, uncorr_cnt.
  - in_ready is 1 from the first cycle after reset.
  - Reset mid-stream drops all in-flight words; no counter is updated for them.
- **Latency.** 2 cycles from input handshake to out_valid, when unstalled.
- **Throughput.** One word per cycle.
- **Stall rules.**
  - Stage 2 loads when !s2_valid or out_ready.
  - Stage 1 loads when !s1_valid or stage 2 loads.
  - in_ready = stage 1 load condition.
  - This gives no bubbles and no combinational path from in_valid to in_ready.
- **Output stability.** While out_valid=1 and out_ready=0, out_* and flags are held stable.
- **Input handshake.** in_code is sampled only when in_valid & in_ready.
- **Flag exclusivity.** out_corrected and out_uncorrectable are never both 1.

## Structure
- **Shared package `hamming_pkg`:**
  - function computing P from DATA_W;
  - function mapping data index to code position;
  - position-is-power-of-two helper.
  - The encoder successor reuses these.
- **Sub-module `hamming_syndrome`:** combinational, parametrised by DATA_W. Produces s and p from a codeword; instantiated in stage 1.
- Top level holds the pipeline registers, the stage 2 correction logic and the counters.

## Test plan
All values use DATA_W=4 (P=3, CODE_W=8). Data 4'hB encodes to 8'hAA.
- **Clean word.** in_code=8'hAA → after 2 cycles: out_data=4'hB, flags 0, syndrome 0; counters unchanged.
- **Single-bit errors.**
  - 8'h8A (bit 5 flipped) → out_data=4'hB, out_corrected=1, syndrome 5; corr_cnt=1.
  - 8'hAB (bit 0 flipped) → out_data=4'hB, out_corrected=1, syndrome 0.
- **Double-bit error.** 8'hCA (bits 5 and 6 flipped) → out_uncorrectable=1, out_data=4'hD (raw), syndrome 3; uncorr_cnt=1.
- **Backpressure.** Stream 8 words back-to-back with out_ready toggled pseudo-randomly. Required:
  - order preserved, no loss or duplication;
  - outputs stable while stalled;
  - full rate when out_ready=1.
- **Counter edges.**
  - CNT_W=2: four corrected words → corr_cnt saturates at 3.
  - cnt_clr asserted in the same cycle as a corrected handshake → corr_cnt=0.
  - rst asserted with 2 words in flight → out_valid=0 and counters=0 next cycle.
